adc_frame_packer: RTL and testbench
===================================

# adc_frame_packer

- Converts per-channel ADC samples (one frame = channels 0..NUM_CH-1, delivered back-to-back by the ADC capture front end) into 32-bit tagged words.
- Pushes those words into `adc_stream_fifo` over its push_valid/push_ready handshake; sits directly upstream of that FIFO.
- Buffers one complete frame and emits it atomically; the FIFO therefore only ever holds whole frames.
- A frame that arrives while the previous one is still draining is dropped whole and counted.

## Interface
Parameters:
- NUM_CH, 8: channels per frame, 2..15.
- SAMPLE_W, 24: raw sample width, fixed ≤24.

Ports:
- clk  in  1  single clock domain.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  capture enable; sampled only at frame start.
- in_valid  in  1  sample strobe. There is no ready; the source cannot stall.
- in_ch  in  4  channel index of the sample.
- in_data  in  SAMPLE_W  raw sample.
- push_valid  out  1  word available to the FIFO.
- push_data  out  32  word to the FIFO.
- push_ready  in  1  FIFO not full.
- frame_seq  out  16  sequence number of the last completed frame.
- frames_dropped  out  16  saturating count of dropped frames.
- drop_clear  in  1  single-cycle pulse that clears frames_dropped.
- proto_err  out  1  sticky flag: channel-order violation.
- err_clear  in  1  single-cycle pulse that clears proto_err.

## Operation
Word formats:
- Sample word: [31:28] channel, [27:24] frame_seq[3:0], [23:0] in_data (zero-extended if SAMPLE_W<24).
- Header word: {8'hA5, NUM_CH[7:0], frame_seq[15:0]}.

States: IDLE, CAPTURE, EMIT_HDR, EMIT_DATA.
- IDLE: in_valid && in_ch==0 && enable → store sample at index 0, go to CAPTURE. Any other in_valid is ignored.
- CAPTURE:
  - in_valid with in_ch equal to the expected index → store the sample and advance the index.
  - The sample at index NUM_CH-1 completes the frame: frame_seq increments (wraps at 0xFFFF), go to EMIT_HDR.
  - in_valid with an unexpected in_ch → abort the frame, set proto_err, go to IDLE. frame_seq does not change.
- EMIT_HDR: present the header; on handshake go to EMIT_DATA with read index 0.
- EMIT_DATA:
  - Present sample words in order 0..NUM_CH-1, advancing on each handshake.
  - After the handshake of the last word, go to IDLE.
- Drop rule: in_valid && in_ch==0 && enable while in EMIT_HDR or EMIT_DATA marks a dropped frame.
  - frames_dropped increments, saturating at 0xFFFF.
  - frame_seq increments, so the host sees the gap.
  - The remaining samples of the dropped frame are ignored.
  - Exception: if in the same cycle the last data word handshakes, the new sample is accepted into index 0 and the block goes to CAPTURE. The sample is not dropped.
- Clear/set collisions:
  - drop_clear together with an increment → frames_dropped becomes 1.
  - err_clear together with a new error → proto_err stays 1.
- enable deasserted mid-frame: the current frame finishes capture and emission.

## Timing
- Reset values: push_valid 0, push_data 0, frame_seq 0, frames_dropped 0, proto_err 0, state IDLE, indices 0.
- Asserting reset mid-frame discards the partial or undrained frame immediately.
- push_valid and push_data are registered.
- The header appears on push_valid in the cycle after the cycle that accepts the final sample.
- Handshake rules:
  - push_valid is never withdrawn, and push_data never changes, while push_ready is 0.
  - One word is transferred per cycle while push_ready is 1.
- Minimum emission time: NUM_CH+1 cycles per frame.

## Configuration
- ADC_PACK_HEADER_EN defined: header word emitted as above; EMIT_HDR is used.
- Not defined:
  - EMIT_HDR is unreachable; CAPTURE goes directly to EMIT_DATA.
  - The frame is NUM_CH words, and minimum emission is NUM_CH cycles.
  - All other behaviour, including frame_seq and the drop rule, is unchanged.

## Structure
- Shared package adc_pkg holds:
  - state encoding;
  - header magic 8'hA5;
  - word field positions: CH_MSB/LSB, SEQ_MSB/LSB, DATA_MSB/LSB.
- Natural sub-module: adc_pack_framebuf. It is an NUM_CH×SAMPLE_W register array with one write port and one registered-address read port, allowing a write to index 0 and a read of index NUM_CH-1 in the same cycle.

## Test plan
- Frame, NUM_CH=8, push_ready=1: samples ch0..7 = 0x000100..0x000107 → 0xA5080001 followed by 0x01000100 … 0x71000107, one word per cycle. The header appears one cycle after ch7 is accepted.
- Backpressure: push_ready=0 for 5 cycles during EMIT_DATA → push_data held stable, no word lost or duplicated, order intact.
- Overlapping frame: start a second frame while the first is still draining under push_ready=0 → frames_dropped=1 and frame_seq=2. The next emitted header carries seq 3.
- Protocol error: ch0, ch1, then ch3 → proto_err=1, nothing pushed, frame_seq unchanged. Then err_clear together with a fresh error → proto_err stays 1.
- Back-to-back boundary: new ch0 arrives in the same cycle as the handshake of the last data word → accepted, no drop, the next frame is emitted intact.
- Reset mid-EMIT_DATA after 3 words → push_valid=0 immediately and all counters 0. The next frame's header carries seq 1.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC frame packer: FSM encoding, header magic,
// and the bit positions of the fields in a 32-bit sample word.
package adc_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned CH_W   = 4;
   localparam int unsigned SEQ_W  = 16;
   localparam int unsigned DATA_W = 24;

   localparam int unsigned CH_MSB   = 31;
   localparam int unsigned CH_LSB   = 28;
   localparam int unsigned SEQ_MSB  = 27;
   localparam int unsigned SEQ_LSB  = 24;
   localparam int unsigned DATA_MSB = 23;
   localparam int unsigned DATA_LSB = 0;

   localparam logic [7:0] HDR_MAGIC = 8'hA5;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_CAPTURE   = 2'd1,
      ST_EMIT_HDR  = 2'd2,
      ST_EMIT_DATA = 2'd3
   } adc_state_e;

   // Sample word: channel, low nibble of the frame sequence, zero-extended data
   function automatic logic [WORD_W-1:0] pack_sample(input logic [CH_W-1:0]   ch,
                                                     input logic [3:0]        seq,
                                                     input logic [DATA_W-1:0] data);
      logic [WORD_W-1:0] w;
      w                    = '0;
      w[CH_MSB:CH_LSB]     = ch;
      w[SEQ_MSB:SEQ_LSB]   = seq;
      w[DATA_MSB:DATA_LSB] = data;
      return w;
   endfunction

   // Header word: magic, channel count, full frame sequence
   function automatic logic [WORD_W-1:0] pack_header(input logic [7:0]       nch,
                                                     input logic [SEQ_W-1:0] seq);
      return {HDR_MAGIC, nch, seq};
   endfunction

endpackage

// File: rtl/adc_pack_framebuf.sv
// One-frame sample store: a single write port plus a read port whose address
// is a registered pointer (reset to 0 or advanced by the packer). A write to
// index 0 and a read of the last index can happen in the same cycle.
module adc_pack_framebuf
   import adc_pkg::*;
#(
   parameter int unsigned NUM_CH   = 8,
   parameter int unsigned SAMPLE_W = 24
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [CH_W-1:0]     wr_addr,
   input  logic [SAMPLE_W-1:0] wr_data,
   input  logic                rd_rst,
   input  logic                rd_adv,
   output logic [CH_W-1:0]     rd_addr,
   output logic [SAMPLE_W-1:0] rd_data_c
);

   localparam int unsigned    AW   = $clog2(NUM_CH);
   localparam logic [CH_W-1:0] LAST = CH_W'(NUM_CH - 1);

   logic [SAMPLE_W-1:0] mem [NUM_CH];

   // Sample storage; contents are only read after being written in this frame
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[AW'(wr_addr)] <= wr_data;
      end
   end

   // Read pointer: rewinds between frames, advances once per loaded word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_addr <= '0;
      end else if (rd_rst) begin
         rd_addr <= '0;
      end else if (rd_adv && (rd_addr != LAST)) begin
         rd_addr <= rd_addr + CH_W'(1);
      end
   end

   assign rd_data_c = mem[AW'(rd_addr)];

endmodule

// File: rtl/adc_frame_packer.sv
// Packs one frame of per-channel ADC samples into 32-bit words and pushes the
// whole frame into the downstream stream FIFO. Frames that start while the
// previous one is still draining are dropped and counted.
// Optional macro ADC_PACK_HEADER_EN: prefix each frame with a header word.
module adc_frame_packer
   import adc_pkg::*;
#(
   parameter int unsigned NUM_CH   = 8,
   parameter int unsigned SAMPLE_W = 24
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                in_valid,
   input  logic [3:0]          in_ch,
   input  logic [SAMPLE_W-1:0] in_data,
   output logic                push_valid,
   output logic [31:0]         push_data,
   input  logic                push_ready,
   output logic [15:0]         frame_seq,
   output logic [15:0]         frames_dropped,
   input  logic                drop_clear,
   output logic                proto_err,
   input  logic                err_clear
);

   localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_CH - 1);
`ifdef ADC_PACK_HEADER_EN
   localparam logic [7:0]      NCH_B    = 8'(NUM_CH);
`endif

   adc_state_e          state;
   logic [CH_W-1:0]     wr_idx;
   logic [CH_W-1:0]     out_idx;
   logic [3:0]          emit_seq;

   logic [CH_W-1:0]     rd_addr;
   logic [SAMPLE_W-1:0] rd_data_c;

   logic                hs_c;
   logic                start_c;
   logic                last_word_c;
   logic                in_order_c;
   logic                complete_c;
   logic                err_set_c;
   logic                drop_c;
   logic [SEQ_W-1:0]    seq_inc_c;
   logic                wr_en_c;
   logic [CH_W-1:0]     wr_addr_c;
   logic                rd_rst_c;
   logic                rd_adv_c;
   logic [3:0]          word_seq_c;
   logic [WORD_W-1:0]   load_word_c;

   adc_pack_framebuf #(
      .NUM_CH   (NUM_CH),
      .SAMPLE_W (SAMPLE_W)
   ) u_framebuf (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en_c),
      .wr_addr   (wr_addr_c),
      .wr_data   (in_data),
      .rd_rst    (rd_rst_c),
      .rd_adv    (rd_adv_c),
      .rd_addr   (rd_addr),
      .rd_data_c (rd_data_c)
   );

   // Handshake, capture, drop and buffer-control decode
   always_comb begin
      hs_c        = push_valid & push_ready;
      start_c     = in_valid & (in_ch == 4'd0) & enable;
      last_word_c = (state == ST_EMIT_DATA) & hs_c & (out_idx == LAST_IDX);
      in_order_c  = (state == ST_CAPTURE) & in_valid & (in_ch == wr_idx);
      complete_c  = in_order_c & (wr_idx == LAST_IDX);
      err_set_c   = (state == ST_CAPTURE) & in_valid & (in_ch != wr_idx);
      drop_c      = ((state == ST_EMIT_HDR) | (state == ST_EMIT_DATA)) & start_c & ~last_word_c;
      seq_inc_c   = frame_seq + SEQ_W'(1);
      wr_en_c     = ((state == ST_IDLE) & start_c) | in_order_c | (last_word_c & start_c);
      wr_addr_c   = (state == ST_CAPTURE) ? wr_idx : '0;
      rd_rst_c    = (state == ST_IDLE) | last_word_c;
      rd_adv_c    = (state == ST_EMIT_DATA) & hs_c & ~last_word_c;
`ifdef ADC_PACK_HEADER_EN
      rd_adv_c    = rd_adv_c | ((state == ST_EMIT_HDR) & hs_c);
`else
      rd_adv_c    = rd_adv_c | complete_c;
`endif
      // word 0 is loaded straight from CAPTURE when there is no header
      word_seq_c  = (state == ST_CAPTURE) ? seq_inc_c[3:0] : emit_seq;
      load_word_c = pack_sample(rd_addr, word_seq_c, DATA_W'(rd_data_c));
   end

   // Frame FSM, output word register and status counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_IDLE;
         wr_idx         <= '0;
         out_idx        <= '0;
         emit_seq       <= '0;
         push_valid     <= 1'b0;
         push_data      <= '0;
         frame_seq      <= '0;
         frames_dropped <= '0;
         proto_err      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_c) begin
                  wr_idx <= CH_W'(1);
                  state  <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (err_set_c) begin
                  wr_idx <= '0;
                  state  <= ST_IDLE;
               end else if (complete_c) begin
                  wr_idx     <= '0;
                  out_idx    <= '0;
                  emit_seq   <= seq_inc_c[3:0];
                  push_valid <= 1'b1;
`ifdef ADC_PACK_HEADER_EN
                  push_data  <= pack_header(NCH_B, seq_inc_c);
                  state      <= ST_EMIT_HDR;
`else
                  push_data  <= load_word_c;
                  state      <= ST_EMIT_DATA;
`endif
               end else if (in_order_c) begin
                  wr_idx <= wr_idx + CH_W'(1);
               end
            end
            ST_EMIT_HDR: begin
               if (hs_c) begin
                  push_data <= load_word_c;
                  out_idx   <= '0;
                  state     <= ST_EMIT_DATA;
               end
            end
            ST_EMIT_DATA: begin
               if (hs_c) begin
                  if (out_idx == LAST_IDX) begin
                     push_valid <= 1'b0;
                     if (start_c) begin
                        wr_idx <= CH_W'(1);
                        state  <= ST_CAPTURE;
                     end else begin
                        state  <= ST_IDLE;
                     end
                  end else begin
                     push_data <= load_word_c;
                     out_idx   <= out_idx + CH_W'(1);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase

         if (complete_c || drop_c) begin
            frame_seq <= seq_inc_c;
         end

         if (drop_clear) begin
            frames_dropped <= drop_c ? 16'd1 : 16'd0;
         end else if (drop_c && (frames_dropped != 16'hFFFF)) begin
            frames_dropped <= frames_dropped + 16'd1;
         end

         if (err_set_c) begin
            proto_err <= 1'b1;
         end else if (err_clear) begin
            proto_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed bench for adc_frame_packer (NUM_CH=8, SAMPLE_W=24). Inputs change
// and outputs are sampled on the falling clock edge.
module tb_adc_frame_packer;

   localparam int unsigned NCH = 8;
`ifdef ADC_PACK_HEADER_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif

   logic        clk        = 1'b0;
   logic        rst        = 1'b1;
   logic        enable     = 1'b0;
   logic        in_valid   = 1'b0;
   logic [3:0]  in_ch      = 4'd0;
   logic [23:0] in_data    = 24'd0;
   logic        push_valid;
   logic [31:0] push_data;
   logic        push_ready = 1'b1;
   logic [15:0] frame_seq;
   logic [15:0] frames_dropped;
   logic        drop_clear = 1'b0;
   logic        proto_err;
   logic        err_clear  = 1'b0;

   int checks = 0;
   int errors = 0;

   adc_frame_packer #(
      .NUM_CH   (NCH),
      .SAMPLE_W (24)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .in_valid       (in_valid),
      .in_ch          (in_ch),
      .in_data        (in_data),
      .push_valid     (push_valid),
      .push_data      (push_data),
      .push_ready     (push_ready),
      .frame_seq      (frame_seq),
      .frames_dropped (frames_dropped),
      .drop_clear     (drop_clear),
      .proto_err      (proto_err),
      .err_clear      (err_clear)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: observed no end of test, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [31:0] sword(input logic [3:0] ch, input logic [3:0] sq,
                                         input logic [23:0] d);
      return {ch, sq, d};
   endfunction

   // Drives channels first..NCH-1 with data base+ch; no word may appear early
   task automatic send_frame(input logic [23:0] base, input int first);
      for (int c = first; c < int'(NCH); c++) begin
         in_valid = 1'b1;
         in_ch    = 4'(c);
         in_data  = base + 24'(c);
         tick();
         in_valid = 1'b0;
         if (c != int'(NCH) - 1) chk($sformatf("idle_ch%0d", c), 32'(push_valid), 32'd0);
      end
   endtask

   // Consumes nwords of the expected frame, optionally stalling before word
   // stall_at and optionally starting a new frame on the last handshake.
   task automatic drain(input string tag, input logic [15:0] seq, input logic [23:0] base,
                        input int nwords, input int stall_at, input int stall_len,
                        input bit b2b, input logic [23:0] b2b_data);
      logic [31:0] exp [$];
      exp = {};
`ifdef ADC_PACK_HEADER_EN
      exp.push_back({8'hA5, 8'(NCH), seq});
`endif
      for (int c = 0; c < int'(NCH); c++) exp.push_back(sword(4'(c), seq[3:0], base + 24'(c)));
      for (int k = 0; k < nwords; k++) begin
         if (k == stall_at) begin
            push_ready = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
               tick();
               chk($sformatf("%s_stall%0d_valid", tag, s), 32'(push_valid), 32'd1);
               chk($sformatf("%s_stall%0d_data", tag, s), push_data, exp[k]);
            end
            push_ready = 1'b1;
         end
         chk($sformatf("%s_w%0d_valid", tag, k), 32'(push_valid), 32'd1);
         chk($sformatf("%s_w%0d_data", tag, k), push_data, exp[k]);
         if (b2b && (k == exp.size() - 1)) begin
            in_valid = 1'b1;
            in_ch    = 4'd0;
            in_data  = b2b_data;
         end
         tick();
         in_valid = 1'b0;
      end
   endtask

   initial begin
      // reset state
      tick();
      tick();
      chk("rst_push_valid", 32'(push_valid), 32'd0);
      chk("rst_push_data", push_data, 32'd0);
      chk("rst_frame_seq", 32'(frame_seq), 32'd0);
      chk("rst_dropped", 32'(frames_dropped), 32'd0);
      chk("rst_proto_err", 32'(proto_err), 32'd0);
      rst    = 1'b0;
      enable = 1'b1;
      tick();

      // basic frame, push_ready held high; first word one cycle after ch7
      send_frame(24'h000100, 0);
      chk("t1_seq", 32'(frame_seq), 32'd1);
      drain("t1", 16'd1, 24'h000100, int'(NCH) + HDR, -1, 0, 1'b0, 24'd0);
      chk("t1_done", 32'(push_valid), 32'd0);

      // backpressure for 5 cycles on data word 2
      send_frame(24'h000200, 0);
      chk("t2_seq", 32'(frame_seq), 32'd2);
      drain("t2", 16'd2, 24'h000200, int'(NCH) + HDR, HDR + 2, 5, 1'b0, 24'd0);
      chk("t2_done", 32'(push_valid), 32'd0);

      // overlapping frame while the previous one is stalled
      send_frame(24'h000300, 0);
      chk("t3_seq_a", 32'(frame_seq), 32'd3);
      push_ready = 1'b0;
      tick();
      for (int c = 0; c < int'(NCH); c++) begin
         in_valid = 1'b1;
         in_ch    = 4'(c);
         in_data  = 24'h0003F0 + 24'(c);
         tick();
         in_valid = 1'b0;
      end
      chk("t3_dropped", 32'(frames_dropped), 32'd1);
      chk("t3_seq_gap", 32'(frame_seq), 32'd4);
      chk("t3_hold_valid", 32'(push_valid), 32'd1);
`ifdef ADC_PACK_HEADER_EN
      chk("t3_hold_data", push_data, 32'hA5080003);
`else
      chk("t3_hold_data", push_data, 32'h03000300);
`endif
      push_ready = 1'b1;
      drain("t3a", 16'd3, 24'h000300, int'(NCH) + HDR, -1, 0, 1'b0, 24'd0);
      chk("t3a_done", 32'(push_valid), 32'd0);
      send_frame(24'h000400, 0);
      chk("t3_seq_b", 32'(frame_seq), 32'd5);
      drain("t3b", 16'd5, 24'h000400, int'(NCH) + HDR, -1, 0, 1'b0, 24'd0);

      // enable dropped mid-frame; drop_clear colliding with a drop
      in_valid = 1'b1;
      in_ch    = 4'd0;
      in_data  = 24'h000500;
      tick();
      in_valid = 1'b0;
      enable   = 1'b0;
      send_frame(24'h000500, 1);
      enable   = 1'b1;
      chk("t4_seq", 32'(frame_seq), 32'd6);
      push_ready = 1'b0;
      in_valid   = 1'b1;
      in_ch      = 4'd0;
      in_data    = 24'h000555;
      drop_clear = 1'b1;
      tick();
      in_valid   = 1'b0;
      drop_clear = 1'b0;
      chk("t4_clear_and_drop", 32'(frames_dropped), 32'd1);
      chk("t4_seq_gap", 32'(frame_seq), 32'd7);
      push_ready = 1'b1;
      drain("t4", 16'd6, 24'h000500, int'(NCH) + HDR, -1, 0, 1'b0, 24'd0);
      drop_clear = 1'b1;
      tick();
      drop_clear = 1'b0;
      chk("t4_cleared", 32'(frames_dropped), 32'd0);

      // protocol error: ch0, ch1, ch3
      in_valid = 1'b1;
      in_ch = 4'd0; in_data = 24'h000010; tick();
      in_ch = 4'd1; in_data = 24'h000011; tick();
      chk("t5_no_err_yet", 32'(proto_err), 32'd0);
      in_ch = 4'd3; in_data = 24'h000013; tick();
      in_valid = 1'b0;
      chk("t5_err", 32'(proto_err), 32'd1);
      chk("t5_no_push", 32'(push_valid), 32'd0);
      chk("t5_seq", 32'(frame_seq), 32'd7);
      in_valid = 1'b1;
      in_ch = 4'd0; tick();
      in_ch = 4'd2; err_clear = 1'b1; tick();
      in_valid  = 1'b0;
      err_clear = 1'b0;
      chk("t5_clear_vs_set", 32'(proto_err), 32'd1);
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      chk("t5_cleared", 32'(proto_err), 32'd0);
      chk("t5_seq_after", 32'(frame_seq), 32'd7);

      // new ch0 on the last data handshake
      send_frame(24'h000600, 0);
      chk("t6_seq_a", 32'(frame_seq), 32'd8);
      drain("t6a", 16'd8, 24'h000600, int'(NCH) + HDR, -1, 0, 1'b1, 24'h000700);
      chk("t6_no_drop", 32'(frames_dropped), 32'd0);
      chk("t6_gap_valid", 32'(push_valid), 32'd0);
      chk("t6_seq_hold", 32'(frame_seq), 32'd8);
      send_frame(24'h000700, 1);
      chk("t6_seq_b", 32'(frame_seq), 32'd9);
      drain("t6b", 16'd9, 24'h000700, int'(NCH) + HDR, -1, 0, 1'b0, 24'd0);
      chk("t6_done", 32'(push_valid), 32'd0);

      // reset after three data words
      send_frame(24'h000800, 0);
      chk("t7_seq", 32'(frame_seq), 32'd10);
      drain("t7", 16'd10, 24'h000800, HDR + 3, -1, 0, 1'b0, 24'd0);
      push_ready = 1'b0;
      in_valid = 1'b1;
      in_ch    = 4'd0;
      in_data  = 24'h000888;
      tick();
      in_valid = 1'b0;
      chk("t7_dropped", 32'(frames_dropped), 32'd1);
      chk("t7_seq_gap", 32'(frame_seq), 32'd11);
      chk("t7_hold", push_data, 32'h3A000803);
      #1;
      rst = 1'b1;
      #1;
      chk("t7_rst_valid", 32'(push_valid), 32'd0);
      chk("t7_rst_seq", 32'(frame_seq), 32'd0);
      chk("t7_rst_dropped", 32'(frames_dropped), 32'd0);
      tick();
      rst        = 1'b0;
      push_ready = 1'b1;
      tick();
      send_frame(24'h000900, 0);
      chk("t7_seq_after", 32'(frame_seq), 32'd1);
      drain("t7b", 16'd1, 24'h000900, int'(NCH) + HDR, -1, 0, 1'b0, 24'd0);
      chk("t7_done", 32'(push_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
